// File: rtl/nbit_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg_pkg
// Description : Shared operation codes for the n-bit register bank and the
//               ALU-side controllers that drive it.
// Revision    : 1.0 - initial release
// ============================================================================
package nbit_reg_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROTL = 3'd4,
        OP_ROTR = 3'd5,
        OP_INC  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

endpackage
`default_nettype wire

// File: rtl/reg_op_unit.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_unit
// Description : Combinational next-value unit. Decodes the operation and
//               produces the new entry value, the write strobe, the next
//               shifted-out bit and the increment wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_op_unit
    import nbit_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    input  logic             sh_cur,
    output logic [WIDTH-1:0] nxt,
    output logic             wr_en,
    output logic             sh_nxt,
    output logic             wrap_nxt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Decode op; a disabled unit behaves exactly like HOLD.
    always_comb begin
        nxt      = cur;
        wr_en    = 1'b0;
        sh_nxt   = sh_cur;
        wrap_nxt = 1'b0;
        if (en) begin
            wr_en = (op != OP_HOLD);
            case (op)
                OP_LOAD: nxt = load_data;
                OP_SHL: begin
                    nxt    = {cur[WIDTH-2:0], ser_in};
                    sh_nxt = cur[WIDTH-1];
                end
                OP_SHR: begin
                    nxt    = {ser_in, cur[WIDTH-1:1]};
                    sh_nxt = cur[0];
                end
                OP_ROTL: begin
                    nxt    = {cur[WIDTH-2:0], cur[WIDTH-1]};
                    sh_nxt = cur[WIDTH-1];
                end
                OP_ROTR: begin
                    nxt    = {cur[0], cur[WIDTH-1:1]};
                    sh_nxt = cur[0];
                end
                OP_INC: begin
                    nxt      = cur + ONE;
                    wrap_nxt = &cur;
                end
                OP_CLR:  nxt = '0;
                default: nxt = cur;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/nbit_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : nbit_reg_bank
// Description : DEPTH x WIDTH register bank with per-entry shift/rotate/inc
//               operations, written-since-reset flags and two registered
//               read ports with write-through bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_reg_bank
    import nbit_reg_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [OP_W-1:0]   Op,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  In,
    input  logic              SerIn,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [WIDTH-1:0]  OutA,
    output logic [WIDTH-1:0]  OutB,
    output logic              ShOut,
    output logic              Wrap,
    output logic              ValidA,
    output logic              ValidB
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [WIDTH-1:0] nxt;
    logic             wr_en;
    logic             sh_nxt;
    logic             wrap_nxt;
    logic             hit_a;
    logic             hit_b;

    reg_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .en        (En),
        .op        (Op),
        .cur       (mem[WrAddr]),
        .load_data (In),
        .ser_in    (SerIn),
        .sh_cur    (ShOut),
        .nxt       (nxt),
        .wr_en     (wr_en),
        .sh_nxt    (sh_nxt),
        .wrap_nxt  (wrap_nxt)
    );

    // A read that targets the entry being written sees the new value.
    assign hit_a = wr_en && (RdAddrA == WrAddr);
    assign hit_b = wr_en && (RdAddrB == WrAddr);

    // Entry storage and written-since-reset flags; reset discards any op.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else if (wr_en) begin
            mem[WrAddr]   <= nxt;
            valid[WrAddr] <= 1'b1;
        end
    end

    // Registered read ports and status flags.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            OutA   <= '0;
            OutB   <= '0;
            ValidA <= 1'b0;
            ValidB <= 1'b0;
            ShOut  <= 1'b0;
            Wrap   <= 1'b0;
        end else begin
            OutA   <= hit_a ? nxt  : mem[RdAddrA];
            OutB   <= hit_b ? nxt  : mem[RdAddrB];
            ValidA <= hit_a ? 1'b1 : valid[RdAddrA];
            ValidB <= hit_b ? 1'b1 : valid[RdAddrB];
            ShOut  <= sh_nxt;
            Wrap   <= wrap_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbit_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_reg_bank
// Description : Self-checking bench for nbit_reg_bank using a reference
//               model feeding an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_reg_bank;
    import nbit_reg_pkg::*;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             va;
        logic             vb;
        logic             sh;
        logic             wr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  din;
    logic              ser_in;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] rd_b;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;
    logic              sh_out;
    logic              wrap;
    logic              valid_a;
    logic              valid_b;

    logic [WIDTH-1:0]  m_mem [DEPTH];
    logic [DEPTH-1:0]  m_valid;
    logic              m_sh;
    exp_t              sb [$];
    exp_t              e;
    int                n_tests = 0;
    int                n_fail  = 0;

    nbit_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk     (clk),
        .Rst     (rst_n),
        .En      (en),
        .Op      (op),
        .WrAddr  (wr_addr),
        .In      (din),
        .SerIn   (ser_in),
        .RdAddrA (rd_a),
        .RdAddrB (rd_b),
        .OutA    (out_a),
        .OutB    (out_b),
        .ShOut   (sh_out),
        .Wrap    (wrap),
        .ValidA  (valid_a),
        .ValidB  (valid_b)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model, queue the expectation,
    // then wait until just after the sampling edge.
    task automatic step(input logic r, input logic e_in, input logic [2:0] o,
                        input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] d,
                        input logic s, input logic [ADDR_W-1:0] ra,
                        input logic [ADDR_W-1:0] rb);
        exp_t x;
        logic [WIDTH-1:0] old;
        @(negedge clk);
        rst_n = r; en = e_in; op = o; wr_addr = wa; din = d; ser_in = s;
        rd_a = ra; rd_b = rb;
        x.wr = 1'b0;
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_valid = '0;
            m_sh    = 1'b0;
            x.a = '0; x.b = '0; x.va = 1'b0; x.vb = 1'b0;
        end else begin
            old = m_mem[wa];
            if (e_in && o != 3'd0) begin
                case (o)
                    3'd1: m_mem[wa] = d;
                    3'd2: begin m_mem[wa] = (old << 1) | {3'b000, s}; m_sh = old[3]; end
                    3'd3: begin m_mem[wa] = (old >> 1) | {s, 3'b000}; m_sh = old[0]; end
                    3'd4: begin m_mem[wa] = (old << 1) | (old >> 3);  m_sh = old[3]; end
                    3'd5: begin m_mem[wa] = (old >> 1) | (old << 3);  m_sh = old[0]; end
                    3'd6: begin m_mem[wa] = old + 4'd1; x.wr = (old == 4'hF); end
                    default: m_mem[wa] = 4'h0;
                endcase
                m_valid[wa] = 1'b1;
            end
            x.a  = m_mem[ra];
            x.b  = m_mem[rb];
            x.va = m_valid[ra];
            x.vb = m_valid[rb];
        end
        x.sh = m_sh;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b1, OP_INC, 2'd0, 4'h3, 1'b1, 2'd0, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL reset_out_a got %h want %h", out_a, e.a); end
        n_tests++; if (out_b   !== e.b)  begin n_fail++; $display("FAIL reset_out_b got %h want %h", out_b, e.b); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL reset_valid_a got %b want %b", valid_a, e.va); end
        n_tests++; if (valid_b !== e.vb) begin n_fail++; $display("FAIL reset_valid_b got %b want %b", valid_b, e.vb); end
        n_tests++; if (sh_out  !== e.sh) begin n_fail++; $display("FAIL reset_sh_out got %b want %b", sh_out, e.sh); end
        n_tests++; if (wrap    !== e.wr) begin n_fail++; $display("FAIL reset_wrap got %b want %b", wrap, e.wr); end
    endtask

    task automatic test_load_read;
        step(1'b1, 1'b1, OP_LOAD, 2'd1, 4'hA, 1'b0, 2'd0, 2'd0);
        e = sb.pop_front();
        n_tests++; if (out_a !== e.a) begin n_fail++; $display("FAIL load_other_entry got %h want %h", out_a, e.a); end
        step(1'b1, 1'b1, OP_HOLD, 2'd0, 4'h0, 1'b0, 2'd1, 2'd2);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL load_out_a got %h want %h", out_a, e.a); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL load_valid_a got %b want %b", valid_a, e.va); end
        n_tests++; if (out_b   !== e.b)  begin n_fail++; $display("FAIL load_out_b got %h want %h", out_b, e.b); end
        n_tests++; if (valid_b !== e.vb) begin n_fail++; $display("FAIL load_valid_b got %b want %b", valid_b, e.vb); end
    endtask

    task automatic test_shift_rotate;
        step(1'b1, 1'b1, OP_LOAD, 2'd0, 4'b1001, 1'b0, 2'd0, 2'd1);
        e = sb.pop_front();
        step(1'b1, 1'b1, OP_SHL, 2'd0, 4'h0, 1'b0, 2'd0, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a  !== e.a)  begin n_fail++; $display("FAIL shl_value got %h want %h", out_a, e.a); end
        n_tests++; if (sh_out !== e.sh) begin n_fail++; $display("FAIL shl_sh_out got %b want %b", sh_out, e.sh); end
        step(1'b1, 1'b1, OP_ROTR, 2'd0, 4'h0, 1'b1, 2'd0, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a  !== e.a)  begin n_fail++; $display("FAIL rotr_value got %h want %h", out_a, e.a); end
        n_tests++; if (sh_out !== e.sh) begin n_fail++; $display("FAIL rotr_sh_out got %b want %b", sh_out, e.sh); end
    endtask

    task automatic test_inc_wrap;
        step(1'b1, 1'b1, OP_LOAD, 2'd3, 4'hF, 1'b0, 2'd3, 2'd0);
        e = sb.pop_front();
        step(1'b1, 1'b1, OP_INC, 2'd3, 4'h0, 1'b0, 2'd3, 2'd0);
        e = sb.pop_front();
        n_tests++; if (out_a !== e.a)  begin n_fail++; $display("FAIL inc_wrap_value got %h want %h", out_a, e.a); end
        n_tests++; if (wrap  !== e.wr) begin n_fail++; $display("FAIL inc_wrap_flag got %b want %b", wrap, e.wr); end
        step(1'b1, 1'b1, OP_INC, 2'd3, 4'h0, 1'b0, 2'd3, 2'd0);
        e = sb.pop_front();
        n_tests++; if (out_a !== e.a)  begin n_fail++; $display("FAIL inc2_value got %h want %h", out_a, e.a); end
        n_tests++; if (wrap  !== e.wr) begin n_fail++; $display("FAIL inc2_wrap got %b want %b", wrap, e.wr); end
    endtask

    task automatic test_bypass;
        step(1'b1, 1'b1, OP_LOAD, 2'd2, 4'h5, 1'b0, 2'd2, 2'd2);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL bypass_out_a got %h want %h", out_a, e.a); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL bypass_valid_a got %b want %b", valid_a, e.va); end
        n_tests++; if (out_b   !== out_a) begin n_fail++; $display("FAIL same_addr_ports got B=%h want A=%h", out_b, out_a); end
    endtask

    task automatic test_enable_low;
        step(1'b1, 1'b0, OP_CLR, 2'd1, 4'h0, 1'b1, 2'd1, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL en_low_value got %h want %h", out_a, e.a); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL en_low_valid got %b want %b", valid_a, e.va); end
        n_tests++; if (sh_out  !== e.sh) begin n_fail++; $display("FAIL en_low_sh_out got %b want %b", sh_out, e.sh); end
    endtask

    task automatic test_reset_priority;
        step(1'b0, 1'b1, OP_LOAD, 2'd0, 4'h7, 1'b0, 2'd0, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL rstpri_out_a got %h want %h", out_a, e.a); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL rstpri_valid_a got %b want %b", valid_a, e.va); end
        n_tests++; if (sh_out  !== e.sh) begin n_fail++; $display("FAIL rstpri_sh_out got %b want %b", sh_out, e.sh); end
        step(1'b1, 1'b1, OP_HOLD, 2'd0, 4'h0, 1'b0, 2'd0, 2'd1);
        e = sb.pop_front();
        n_tests++; if (out_a   !== e.a)  begin n_fail++; $display("FAIL rstpri_entry got %h want %h", out_a, e.a); end
        n_tests++; if (valid_a !== e.va) begin n_fail++; $display("FAIL rstpri_entry_valid got %b want %b", valid_a, e.va); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            e = sb.pop_front();
            n_tests++;
            if (out_a !== e.a || out_b !== e.b || valid_a !== e.va ||
                valid_b !== e.vb || sh_out !== e.sh || wrap !== e.wr) begin
                n_fail++;
                $display("FAIL random_%0d got A=%h B=%h VA=%b VB=%b SH=%b W=%b want A=%h B=%h VA=%b VB=%b SH=%b W=%b",
                         k, out_a, out_b, valid_a, valid_b, sh_out, wrap,
                         e.a, e.b, e.va, e.vb, e.sh, e.wr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; op = 3'd0; wr_addr = '0; din = '0;
        ser_in = 1'b0; rd_a = '0; rd_b = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_valid = '0;
        m_sh    = 1'b0;
        test_reset();
        test_load_read();
        test_shift_rotate();
        test_inc_wrap();
        test_bypass();
        test_enable_low();
        test_reset_priority();
        test_random();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
